// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM encoding, default operand width and shift fill modes.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ALU_WIDTH = 8;

    localparam logic SHIFT_LOGIC = 1'b0;
    localparam logic SHIFT_ARITH = 1'b1;

endpackage

// File: rtl/shift_right_sequencer_if.sv
// Request/result bundle between the ALU op decoder and the right-shift sequencer.
interface shift_right_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start;
    logic             arith;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;

    modport master (
        output start, arith, amt, a_in, b_in,
        input  busy, done, res_a, res_b
    );

    modport slave (
        input  start, arith, amt, a_in, b_in,
        output busy, done, res_a, res_b
    );
endinterface

// File: rtl/shift_right_step.sv
// Single-bit right shift of two operands, zero fill or sign fill.
module shift_right_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             arith,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out
);

    logic fill_a;
    logic fill_b;

    assign fill_a = (arith == SHIFT_ARITH) ? a[WIDTH-1] : 1'b0;
    assign fill_b = (arith == SHIFT_ARITH) ? b[WIDTH-1] : 1'b0;

    assign a_out = {fill_a, a[WIDTH-1:1]};
    assign b_out = {fill_b, b[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_sequencer.sv
// Multi-cycle variable right shifter: one single-bit step per clock, start/busy/done handshake.
module shift_right_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int AMT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_right_sequencer_if.slave  bus
);

    state_t           state_q, state_nxt;
    logic [AMT_W-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;
    logic             arith_q, arith_nxt;
    logic [WIDTH-1:0] res_a_q, res_a_nxt, res_b_q, res_b_nxt;
    logic [WIDTH-1:0] a_step, b_step;
    logic [AMT_W-1:0] amt_clamped;

    // Amounts beyond the operand width behave exactly like a full-width shift.
    function automatic logic [AMT_W-1:0] clamp_amt(input logic [AMT_W-1:0] amt);
        if (int'(amt) > WIDTH) return AMT_W'(WIDTH);
        return amt;
    endfunction

    assign amt_clamped = clamp_amt(bus.amt);

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .a     (a_q),
        .b     (b_q),
        .arith (arith_q),
        .a_out (a_step),
        .b_out (b_step)
    );

    always_comb begin
        state_nxt = state_q;
        count_nxt = count_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        arith_nxt = arith_q;
        res_a_nxt = res_a_q;
        res_b_nxt = res_b_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_nxt     = bus.a_in;
                    b_nxt     = bus.b_in;
                    arith_nxt = bus.arith;
                    count_nxt = amt_clamped;
                    state_nxt = (amt_clamped == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                a_nxt     = a_step;
                b_nxt     = b_step;
                count_nxt = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Results are captured only on DONE entry so intermediate steps never show.
        if (state_q != DONE && state_nxt == DONE) begin
            res_a_nxt = a_nxt;
            res_b_nxt = b_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            arith_q <= 1'b0;
            res_a_q <= '0;
            res_b_q <= '0;
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            arith_q <= arith_nxt;
            res_a_q <= res_a_nxt;
            res_b_q <= res_b_nxt;
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.res_a = res_a_q;
    assign bus.res_b = res_b_q;

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Directed bench for shift_right_sequencer: vector table plus handshake and reset sequences.
module tb_shift_right_sequencer;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    logic prev_done = 1'b0;
    bit   mon_en = 1'b0;

    shift_right_sequencer_if #(.WIDTH(8), .AMT_W(4)) bus ();

    shift_right_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] amt;
        logic       ar;
        logic [7:0] ea;
        logic [7:0] eb;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Per-cycle protocol checks
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("busy_vs_state", int'(bus.busy), int'(dut.state_q != IDLE));
            check("done_single_pulse", int'(prev_done & bus.done), 0);
        end
        prev_done = rst ? 1'b0 : bus.done;
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] amt,
                          input logic ar, output int lat, output bit held);
        logic [7:0] ra0, rb0;
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = a; bus.b_in = b; bus.amt = amt; bus.arith = ar;
        ra0 = bus.res_a; rb0 = bus.res_b;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.a_in = ~a; bus.b_in = ~b; bus.amt = 4'hF; bus.arith = ~ar;
        held = 1'b1;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.res_a !== ra0 || bus.res_b !== rb0) held = 1'b0;
        end
    endtask

    initial begin
        int  lat;
        bit  held;
        int  dones;
        bus.start = 1'b0; bus.arith = 1'b0; bus.amt = '0; bus.a_in = '0; bus.b_in = '0;

        vecs[0]  = '{8'h08, 8'h08, 4'd1,  1'b0, 8'h04, 8'h04, 2};
        vecs[1]  = '{8'hFF, 8'hFF, 4'd8,  1'b0, 8'h00, 8'h00, 9};
        vecs[2]  = '{8'hFF, 8'hFF, 4'd8,  1'b1, 8'hFF, 8'hFF, 9};
        vecs[3]  = '{8'hFF, 8'hFF, 4'd15, 1'b0, 8'h00, 8'h00, 9};
        vecs[4]  = '{8'hFF, 8'hFF, 4'd15, 1'b1, 8'hFF, 8'hFF, 9};
        vecs[5]  = '{8'h01, 8'h80, 4'd0,  1'b0, 8'h01, 8'h80, 1};
        vecs[6]  = '{8'h01, 8'h80, 4'd3,  1'b1, 8'h00, 8'hF0, 4};
        vecs[7]  = '{8'h96, 8'h69, 4'd4,  1'b0, 8'h09, 8'h06, 5};
        vecs[8]  = '{8'h96, 8'h69, 4'd4,  1'b1, 8'hF9, 8'h06, 5};
        vecs[9]  = '{8'h80, 8'h7F, 4'd7,  1'b1, 8'hFF, 8'h00, 8};
        vecs[10] = '{8'hC3, 8'h3C, 4'd2,  1'b0, 8'h30, 8'h0F, 3};

        rst = 1'b1;
        #12;
        check("reset_busy",  int'(bus.busy),  0);
        check("reset_done",  int'(bus.done),  0);
        check("reset_res_a", int'(bus.res_a), 0);
        check("reset_res_b", int'(bus.res_b), 0);
        #10 rst = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 11; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].amt, vecs[v].ar, lat, held);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d_res_a", v), int'(bus.res_a), int'(vecs[v].ea));
            check($sformatf("vec%0d_res_b", v), int'(bus.res_b), int'(vecs[v].eb));
            check($sformatf("vec%0d_res_held", v), int'(held), 1);
            @(negedge clk);
            check($sformatf("vec%0d_idle_after", v), int'(bus.busy), 0);
            check($sformatf("vec%0d_res_kept", v), int'(bus.res_a), int'(vecs[v].ea));
        end

        // start held high with operands changing after accept
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 8'h96; bus.b_in = 8'h69; bus.amt = 4'd4; bus.arith = 1'b0;
        @(posedge clk);
        #1;
        bus.a_in = 8'hFF; bus.b_in = 8'hFF;
        dones = 0; lat = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                lat = i;
            end
        end
        check("held_start_done_count", dones, 1);
        check("held_start_latency", lat, 5);
        check("held_start_res_a", int'(bus.res_a), 8'h09);
        check("held_start_res_b", int'(bus.res_b), 8'h06);
        @(negedge clk);
        check("held_start_idle_gap", int'(bus.busy), 0);
        @(negedge clk);
        check("held_start_second_accept", int'(bus.busy), 1);
        bus.start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check("second_req_latency", lat, 5);
        check("second_req_res_a", int'(bus.res_a), 8'h0F);
        check("second_req_res_b", int'(bus.res_b), 8'h0F);
        @(negedge clk);
        check("second_req_idle_after", int'(bus.busy), 0);

        // asynchronous reset while three steps remain
        @(negedge clk);
        bus.start = 1'b1; bus.a_in = 8'hF0; bus.b_in = 8'h0F; bus.amt = 4'd5; bus.arith = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midshift_rst_busy",  int'(bus.busy),  0);
        check("midshift_rst_done",  int'(bus.done),  0);
        check("midshift_rst_res_a", int'(bus.res_a), 0);
        check("midshift_rst_res_b", int'(bus.res_b), 0);
        #12 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midshift_rst_no_done", dones, 0);
        run_op(8'h81, 8'h7E, 4'd3, 1'b1, lat, held);
        check("post_rst_latency", lat, 4);
        check("post_rst_res_a", int'(bus.res_a), 8'hF0);
        check("post_rst_res_b", int'(bus.res_b), 8'h0F);
        @(negedge clk);
        check("post_rst_idle_after", int'(bus.busy), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
